// File: rtl/fetch_align_buf_pkg.sv
// Shared types and defaults for the instruction fetch/realignment front end.
// RVC support in the fetch buffer is enabled by defining FETCH_RVC_EN.
package fetch_align_buf_pkg;

    typedef logic [15:0] parcel_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } fetch_out_t;

    // A halfword whose low two bits differ from this pattern is a complete RVC instruction.
    localparam logic [1:0] RVC_MASK = 2'b11;

    localparam int DEPTH_HW_DEF  = 6;
    localparam int MAX_OUTST_DEF = 2;

endpackage

// File: rtl/fetch_parcel_fifo.sv
// Circular halfword FIFO: pushes 0/1/2 parcels and pops 0/1/2 parcels per cycle,
// exposing the two head parcels so a straddling 32-bit instruction can be read
// across the wrap point.
module fetch_parcel_fifo
    import fetch_align_buf_pkg::*;
#(
    parameter  int DEPTH = DEPTH_HW_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic [1:0]    i_push_n,
    input  parcel_t       i_push_p0,
    input  parcel_t       i_push_p1,
    input  logic [1:0]    i_pop_n,
    output logic [CW-1:0] o_count,
    output parcel_t       o_peek0,
    output parcel_t       o_peek1
);

    localparam int PW = $clog2(DEPTH);

    parcel_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wr_nxt1;
    logic [PW-1:0] w_rd_nxt1;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign w_wr_nxt1 = ptr_add(r_wr_ptr, 2'd1);
    assign w_rd_nxt1 = ptr_add(r_rd_ptr, 2'd1);

    // Pointer and occupancy update; clear empties the queue without touching storage.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= ptr_add(r_wr_ptr, i_push_n);
            r_rd_ptr <= ptr_add(r_rd_ptr, i_pop_n);
            r_count  <= r_count + CW'(i_push_n) - CW'(i_pop_n);
        end
    end

    // Parcel storage; low parcel lands at the write pointer, high parcel right after it.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_clear) begin
            if (i_push_n != 2'd0) r_mem[r_wr_ptr]  <= i_push_p0;
            if (i_push_n == 2'd2) r_mem[w_wr_nxt1] <= i_push_p1;
        end
    end

    assign o_count = r_count;
    assign o_peek0 = r_mem[r_rd_ptr];
    assign o_peek1 = r_mem[w_rd_nxt1];

endmodule

// File: rtl/fetch_align_buf.sv
// Instruction prefetch and realignment queue. Fetches aligned words, splits them
// into parcels and presents one whole instruction (16- or 32-bit) with its PC.
// Redirects discard queued parcels and responses still in flight.
// Optional: FETCH_RVC_EN enables compressed instructions and halfword redirect targets.
module fetch_align_buf
    import fetch_align_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH_HW  = DEPTH_HW_DEF,
    parameter int          MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_comp
);

    localparam int CW = $clog2(DEPTH_HW + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_pc;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] r_drop;

    logic [CW-1:0] w_count;
    parcel_t       w_peek0;
    parcel_t       w_peek1;
    logic [1:0]    w_push_n;
    parcel_t       w_push_p0;
    parcel_t       w_push_p1;
    logic [1:0]    w_pop_n;
    logic          w_grant;
    logic          w_keep;
    logic          w_is_comp;
    logic          w_valid;
    int            w_free_hw;
    int            w_need_hw;
    fetch_out_t    w_head;
    logic          w_unused;

`ifdef FETCH_RVC_EN
    logic          r_skip;
`endif

    fetch_parcel_fifo #(.DEPTH(DEPTH_HW)) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (i_flush),
        .i_push_n  (w_push_n),
        .i_push_p0 (w_push_p0),
        .i_push_p1 (w_push_p1),
        .i_pop_n   (w_pop_n),
        .o_count   (w_count),
        .o_peek0   (w_peek0),
        .o_peek1   (w_peek1)
    );

    // Request only when every outstanding response plus this one is guaranteed room.
    always_comb begin
        w_free_hw = DEPTH_HW - int'(w_count);
        w_need_hw = 2 * (int'(r_outst) + 1);
        o_mem_req = !i_reset && (int'(r_outst) < MAX_OUTST) && (w_free_hw >= w_need_hw);
        w_grant   = o_mem_req && i_mem_gnt;
    end

    assign o_mem_addr = r_fetch_addr;

    // Head decode: instruction length from the first parcel, outputs zeroed until complete.
    always_comb begin
`ifdef FETCH_RVC_EN
        w_is_comp = (w_peek0[1:0] != RVC_MASK);
`else
        w_is_comp = 1'b0;
`endif
        w_valid = w_is_comp ? (w_count >= CW'(1)) : (w_count >= CW'(2));
        w_head      = '0;
        w_head.pc   = r_pc;
        if (w_valid) begin
            w_head.comp  = w_is_comp;
            w_head.instr = w_is_comp ? {16'h0000, w_peek0} : {w_peek1, w_peek0};
        end
    end

    assign o_instr_valid = w_valid;
    assign o_instr       = w_head.instr;
    assign o_instr_pc    = w_head.pc;
    assign o_instr_comp  = w_head.comp;

    // Response routing: drop stale words; after an odd redirect keep only the high parcel.
    always_comb begin
        w_keep    = i_mem_rvalid && (r_drop == '0) && !i_flush;
        w_push_n  = 2'd0;
        w_push_p0 = i_mem_rdata[15:0];
        w_push_p1 = i_mem_rdata[31:16];
        if (w_keep) begin
            w_push_n = 2'd2;
`ifdef FETCH_RVC_EN
            if (r_skip) begin
                w_push_n  = 2'd1;
                w_push_p0 = i_mem_rdata[31:16];
            end
`endif
        end
        w_pop_n = 2'd0;
        if (w_valid && i_instr_ready && !i_flush) w_pop_n = w_is_comp ? 2'd1 : 2'd2;
    end

    // Fetch address, PC, in-flight and drop tracking; a redirect turns everything in flight into drops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_addr <= RESET_PC;
            r_pc         <= RESET_PC;
            r_outst      <= '0;
            r_drop       <= '0;
        end else begin
            r_outst <= r_outst + OW'(w_grant) - OW'(i_mem_rvalid);
            if (i_flush) begin
                r_fetch_addr <= {i_flush_pc[31:2], 2'b00};
`ifdef FETCH_RVC_EN
                r_pc         <= {i_flush_pc[31:1], 1'b0};
`else
                r_pc         <= {i_flush_pc[31:2], 2'b00};
`endif
                r_drop       <= r_outst + OW'(w_grant) - OW'(i_mem_rvalid);
            end else begin
                if (w_grant) r_fetch_addr <= r_fetch_addr + 32'd4;
                if (i_mem_rvalid && (r_drop != '0)) r_drop <= r_drop - OW'(1);
                if (w_pop_n != 2'd0) r_pc <= r_pc + ((w_pop_n == 2'd1) ? 32'd2 : 32'd4);
            end
        end
    end

`ifdef FETCH_RVC_EN
    // Odd-skip flag: set by a redirect to the upper halfword, consumed by the first kept response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_skip <= 1'b0;
        end else if (i_flush) begin
            r_skip <= i_flush_pc[1];
        end else if (w_keep) begin
            r_skip <= 1'b0;
        end
    end
`endif

    assign w_unused = ^i_flush_pc[1:0];

endmodule

// File: tb/tb_fetch_align_buf.sv
// Randomized bench for fetch_align_buf. The reference is the architectural view:
// the instruction stream is read directly from a memory image starting at the
// current PC, independent of how the DUT queues parcels.
module tb_fetch_align_buf;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH_HW  = 6;
    localparam int          MAX_OUTST = 2;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } req_t;

    logic        clk = 1'b0;
    logic        reset, flush, mem_gnt, mem_rvalid, instr_ready;
    logic [31:0] flush_pc, mem_rdata;
    logic        mem_req, instr_valid, instr_comp;
    logic [31:0] mem_addr, instr, instr_pc;

    logic [31:0] mem_tab [256];
    req_t        q[$];
    logic [31:0] mpc, exp_fetch;
    int          n_cmp = 0, n_err = 0, n_ret = 0, cyc = 0, stall = 0;
    bit          post_reset = 1'b0;

    fetch_align_buf #(.RESET_PC(RESET_PC), .DEPTH_HW(DEPTH_HW), .MAX_OUTST(MAX_OUTST)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_gnt     (mem_gnt),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_comp  (instr_comp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return mem_tab[a[9:2]];
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = memword(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] target_pc(input logic [31:0] fpc);
`ifdef FETCH_RVC_EN
        return {fpc[31:1], 1'b0};
`else
        return {fpc[31:2], 2'b00};
`endif
    endfunction

    // One clock: drive inputs after the falling edge, check settled outputs, advance the models.
    task automatic step(input bit do_reset, input bit do_flush, input logic [31:0] fpc,
                        input int ready_pct, input bit force_rv);
        bit          rv, hs;
        logic [15:0] h0;
        logic [31:0] e_instr;
        logic        e_comp;
        int          len;
        @(negedge clk);
        cyc++;
        reset       = do_reset;
        flush       = do_flush && !do_reset;
        flush_pc    = fpc;
        instr_ready = ($urandom_range(0, 99) < ready_pct);
        mem_gnt     = ($urandom_range(0, 3) != 0);
        rv = !do_reset && (q.size() > 0) && (q[0].cyc < cyc) && (force_rv || ($urandom_range(0, 2) != 0));
        mem_rvalid  = rv;
        mem_rdata   = rv ? memword(q[0].addr) : $urandom;
        #1;
        if (post_reset) begin
            post_reset = 1'b0;
            check_eq("rst_valid", instr_valid, 0);
            check_eq("rst_instr", instr, 0);
            check_eq("rst_comp", instr_comp, 0);
            check_eq("rst_pc", instr_pc, RESET_PC);
            check_eq("rst_addr", mem_addr, RESET_PC);
        end
        if (do_reset) begin
            check_eq("req_in_reset", mem_req, 0);
            q.delete();
            mpc        = RESET_PC;
            exp_fetch  = RESET_PC;
            post_reset = 1'b1;
            stall      = 0;
            return;
        end
        if (mem_req) begin
            check_eq("mem_addr", mem_addr, exp_fetch);
            check_eq("req_outst", q.size() < MAX_OUTST, 1);
        end
        if (instr_valid) check_eq("instr_pc", instr_pc, mpc);
        hs = instr_valid && instr_ready && !flush;
        if (hs) begin
`ifdef FETCH_RVC_EN
            h0 = hw(mpc);
            if (h0[1:0] != 2'b11) begin
                e_instr = {16'h0000, h0}; e_comp = 1'b1; len = 2;
            end else begin
                e_instr = {hw(mpc + 32'd2), h0}; e_comp = 1'b0; len = 4;
            end
`else
            h0      = 16'h0;
            e_instr = memword(mpc); e_comp = 1'b0; len = 4;
`endif
            check_eq("instr", instr, e_instr);
            check_eq("comp", instr_comp, e_comp);
            mpc = mpc + len;
            n_ret++;
        end
        if (rv) void'(q.pop_front());
        if (mem_req && mem_gnt) begin
            q.push_back('{addr: mem_addr, cyc: cyc});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (flush) begin
            mpc       = target_pc(fpc);
            exp_fetch = {fpc[31:2], 2'b00};
        end
        if (hs || flush || ready_pct == 0) stall = 0;
        else stall++;
        if (ready_pct > 0) check_eq("progress", stall > 150, 0);
    endtask

    task automatic run(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, ready_pct, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; flush_pc = '0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_tab[i] = $urandom;
        mem_tab[0] = 32'h0313_0001;
        mem_tab[1] = 32'hABCD_0013;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 0, 1'b0);
        run(60, 70);

        // Consumer stalled: fill the queue, then requests must stop with nothing in flight.
        run(40, 0);
        check_eq("stall_req_off", mem_req, 0);
        check_eq("stall_inflight", q.size(), 0);

        // Reset with a full queue.
        step(1'b1, 1'b0, 32'h0, 0, 1'b0);
        run(30, 70);

        // Redirect to an odd halfword, preferably with two requests in flight.
        for (int i = 0; i < 200 && q.size() != 2; i++) step(1'b0, 1'b0, 32'h0, 70, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0106, 70, 1'b0);
        run(40, 70);

        // Redirect in the same cycle as a response.
        for (int i = 0; i < 200 && !(q.size() > 0 && q[0].cyc <= cyc); i++) step(1'b0, 1'b0, 32'h0, 70, 1'b0);
        step(1'b0, 1'b1, $urandom & 32'h3FF, 70, 1'b1);
        run(40, 70);

        // Random mix of redirects, resets and consumer stalls.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 5)       step(1'b1, 1'b0, 32'h0, 50, 1'b0);
            else if (r < 35) step(1'b0, 1'b1, $urandom & 32'h3FF, 60, $urandom_range(0, 1) == 1);
            else             step(1'b0, 1'b0, 32'h0, (i / 200) % 2 == 0 ? 80 : 35, 1'b0);
        end
        check_eq("enough_retired", n_ret >= 300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
